// File: rtl/alu_cmd_engine.sv
// alu_cmd_engine: single-stage ALU pipeline feeding an in-order result FIFO.
// A command is captured into the s1 execute register on accept; the result is
// computed combinationally from s1 and written into the FIFO on the next edge.
// cmd_ready counts s1 as a reserved FIFO slot, so the FIFO can never overflow.
//
//   state     | meaning
//   ----------+-------------------------------------------------
//   S1_EMPTY  | execute register holds no command
//   S1_LOADED | execute register holds a command, pushed next edge

module alu_cmd_engine #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [15:0] cmd_x,
  input  logic [15:0] cmd_y,
  input  logic [2:0]  cmd_sel,
  input  logic [3:0]  cmd_tag,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_data,
  output logic        rsp_carry,
  output logic        rsp_borrow,
  output logic [3:0]  rsp_tag,
  output logic [15:0] done_count
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_NOT = 3'b101;
  localparam logic [2:0] OP_SHL = 3'b110;
  localparam logic [2:0] OP_SHR = 3'b111;

  typedef enum logic {
    S1_EMPTY  = 1'b0,
    S1_LOADED = 1'b1
  } s1_state_e;

  typedef struct packed {
    logic [3:0]  tag;
    logic        borrow;
    logic        carry;
    logic [15:0] data;
  } res_t;

  s1_state_e      s1_state_q;
  logic [15:0]    s1_x_q;
  logic [15:0]    s1_y_q;
  logic [2:0]     s1_sel_q;
  logic [3:0]     s1_tag_q;
  logic           s1_valid;

  res_t           fifo_mem_q [FIFO_DEPTH];
  logic [PW-1:0]  wr_ptr_q;
  logic [PW-1:0]  rd_ptr_q;
  logic [CW-1:0]  fifo_count_q;
  logic [CW-1:0]  fifo_count_d;
  logic [15:0]    done_count_q;

  logic [CW-1:0]  outstanding;
  logic           accept;
  logic           push;
  logic           pop;
  logic [16:0]    sum17;
  logic [16:0]    diff17;
  res_t           res_d;
  res_t           head;

  assign s1_valid = (s1_state_q == S1_LOADED);

  // Slots in use include the command sitting in s1; reset forces ready low.
  assign outstanding = fifo_count_q + {{PW{1'b0}}, s1_valid};
  assign cmd_ready   = ~rst & (outstanding < DEPTH_C);

  assign accept = cmd_valid & cmd_ready;
  assign push   = s1_valid;
  assign pop    = rsp_valid & rsp_ready;

  assign sum17  = {1'b0, s1_x_q} + {1'b0, s1_y_q};
  assign diff17 = {1'b0, s1_x_q} - {1'b0, s1_y_q};

  // ALU: compute the result of the command held in s1.
  always_comb begin
    res_d     = '0;
    res_d.tag = s1_tag_q;
    case (s1_sel_q)
      OP_ADD: begin
        res_d.data  = sum17[15:0];
        res_d.carry = sum17[16];
      end
      OP_SUB: begin
        res_d.data   = diff17[15:0];
        res_d.borrow = diff17[16];
      end
      OP_AND:  res_d.data = s1_x_q & s1_y_q;
      OP_OR:   res_d.data = s1_x_q | s1_y_q;
      OP_XOR:  res_d.data = s1_x_q ^ s1_y_q;
      OP_NOT:  res_d.data = ~s1_x_q;
      OP_SHL:  res_d.data = {s1_x_q[14:0], 1'b0};
      OP_SHR:  res_d.data = {1'b0, s1_x_q[15:1]};
      default: res_d.data = '0;
    endcase
  end

  // s1 execute-stage FSM and command payload capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_state_q <= S1_EMPTY;
      s1_x_q     <= '0;
      s1_y_q     <= '0;
      s1_sel_q   <= '0;
      s1_tag_q   <= '0;
    end else begin
      case (s1_state_q)
        S1_EMPTY:  s1_state_q <= accept ? S1_LOADED : S1_EMPTY;
        S1_LOADED: s1_state_q <= accept ? S1_LOADED : S1_EMPTY;
        default:   s1_state_q <= S1_EMPTY;
      endcase
      if (accept) begin
        s1_x_q   <= cmd_x;
        s1_y_q   <= cmd_y;
        s1_sel_q <= cmd_sel;
        s1_tag_q <= cmd_tag;
      end
    end
  end

  // Result storage; contents are don't-care until counted valid.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem_q[wr_ptr_q] <= res_d;
    end
  end

  // Occupancy: simultaneous push and pop leaves the count unchanged.
  always_comb begin
    fifo_count_d = fifo_count_q;
    case ({push, pop})
      2'b10:   fifo_count_d = fifo_count_q + CW'(1);
      2'b01:   fifo_count_d = fifo_count_q - CW'(1);
      default: fifo_count_d = fifo_count_q;
    endcase
  end

  // FIFO pointers and count; pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      fifo_count_q <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
      fifo_count_q <= fifo_count_d;
    end
  end

  // Pop counter, wraps at 16 bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      done_count_q <= '0;
    end else if (pop) begin
      done_count_q <= done_count_q + 16'd1;
    end
  end

  assign head       = fifo_mem_q[rd_ptr_q];
  assign rsp_valid  = (fifo_count_q != '0);
  assign rsp_data   = rsp_valid ? head.data   : '0;
  assign rsp_carry  = rsp_valid ? head.carry  : 1'b0;
  assign rsp_borrow = rsp_valid ? head.borrow : 1'b0;
  assign rsp_tag    = rsp_valid ? head.tag    : '0;
  assign done_count = done_count_q;

endmodule

// File: tb/tb_alu_cmd_engine.sv
// tb_alu_cmd_engine: directed literal checks plus randomized traffic compared
// every cycle against a transaction-level model (queue of outstanding results).
module tb_alu_cmd_engine;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [15:0] cmd_x = '0;
  logic [15:0] cmd_y = '0;
  logic [2:0]  cmd_sel = '0;
  logic [3:0]  cmd_tag = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [15:0] rsp_data;
  logic        rsp_carry;
  logic        rsp_borrow;
  logic [3:0]  rsp_tag;
  logic [15:0] done_count;

  alu_cmd_engine #(.FIFO_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_x      (cmd_x),
    .cmd_y      (cmd_y),
    .cmd_sel    (cmd_sel),
    .cmd_tag    (cmd_tag),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rsp_carry  (rsp_carry),
    .rsp_borrow (rsp_borrow),
    .rsp_tag    (rsp_tag),
    .done_count (done_count)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [15:0] d;
    logic        c;
    logic        b;
    logic [3:0]  t;
    int          vis;
  } res_t;

  res_t        mq[$];
  int          ecnt = 0;
  logic [15:0] mdone = '0;
  bit          started = 1'b0;
  bit          fresh = 1'b1;

  function automatic res_t golden(input logic [15:0] x, input logic [15:0] y,
                                  input logic [2:0] sel, input logic [3:0] tag);
    res_t r;
    int   xi;
    int   yi;
    int   v;
    xi = int'(x);
    yi = int'(y);
    r.c = 1'b0;
    r.b = 1'b0;
    r.t = tag;
    r.vis = 0;
    r.d = '0;
    case (sel)
      3'd0: begin v = xi + yi; r.d = 16'(v % 65536); r.c = (v > 65535); end
      3'd1: begin r.b = (xi < yi); r.d = 16'((xi - yi + 65536) % 65536); end
      3'd2: r.d = x & y;
      3'd3: r.d = x | y;
      3'd4: r.d = x ^ y;
      3'd5: r.d = 16'(65535 - xi);
      3'd6: r.d = 16'((xi * 2) % 65536);
      default: r.d = 16'(xi / 2);
    endcase
    return r;
  endfunction

  // Model update at each rising edge: a command accepted at edge k is visible
  // after edge k+1; outstanding results (in s1 or queued) limit acceptance.
  initial begin
    forever begin
      @(posedge clk);
      if (rst) begin
        mq.delete();
        mdone = '0;
        started = 1'b1;
        fresh = 1'b1;
      end else if (started) begin
        bit rdy;
        rdy = (mq.size() < DEPTH);
        if (mq.size() > 0 && mq[0].vis <= ecnt && rsp_ready) begin
          void'(mq.pop_front());
          mdone++;
          fresh = 1'b0;
        end
        if (cmd_valid && rdy) begin
          res_t r;
          r = golden(cmd_x, cmd_y, cmd_sel, cmd_tag);
          r.vis = ecnt + 2;
          mq.push_back(r);
        end
      end
      ecnt++;
    end
  end

  // Per-cycle comparison against the model, sampled mid-cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (started) begin
        bit exp_rdy;
        bit exp_v;
        exp_rdy = !rst && (mq.size() < DEPTH);
        exp_v   = (mq.size() > 0) && (mq[0].vis <= ecnt);
        chk("cmd_ready", 32'(cmd_ready), 32'(exp_rdy));
        chk("rsp_valid", 32'(rsp_valid), 32'(exp_v));
        chk("done_count", 32'(done_count), 32'(mdone));
        if (exp_v) begin
          chk("rsp_data", 32'(rsp_data), 32'(mq[0].d));
          chk("rsp_carry", 32'(rsp_carry), 32'(mq[0].c));
          chk("rsp_borrow", 32'(rsp_borrow), 32'(mq[0].b));
          chk("rsp_tag", 32'(rsp_tag), 32'(mq[0].t));
        end else if (fresh) begin
          chk("rsp_idle_zero", 32'({rsp_data, rsp_carry, rsp_borrow, rsp_tag}), 32'd0);
        end
      end
    end
  end

  // ---------------- directed helpers ----------------
  task automatic run_one(input string name, input logic [15:0] x, input logic [15:0] y,
                         input logic [2:0] sel, input logic [3:0] tag,
                         input logic [15:0] ed, input logic ec, input logic eb);
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_x = x; cmd_y = y; cmd_sel = sel; cmd_tag = tag;
    rsp_ready = 1'b0;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(negedge clk);
    chk({name, "_lat1"}, 32'(rsp_valid), 32'd0);
    @(negedge clk);
    chk({name, "_valid"}, 32'(rsp_valid), 32'd1);
    chk({name, "_data"}, 32'(rsp_data), 32'(ed));
    chk({name, "_carry"}, 32'(rsp_carry), 32'(ec));
    chk({name, "_borrow"}, 32'(rsp_borrow), 32'(eb));
    chk({name, "_tag"}, 32'(rsp_tag), 32'(tag));
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int acc;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_valid", 32'(rsp_valid), 32'd0);
    chk("post_rst_ready", 32'(cmd_ready), 32'd1);
    chk("post_rst_done", 32'(done_count), 32'd0);
    chk("post_rst_rsp", 32'({rsp_data, rsp_carry, rsp_borrow, rsp_tag}), 32'd0);

    run_one("add_ovf", 16'hFFFF, 16'h0001, 3'b000, 4'd3, 16'h0000, 1'b1, 1'b0);
    run_one("sub_neg", 16'h0001, 16'h0002, 3'b001, 4'd1, 16'hFFFF, 1'b0, 1'b1);
    run_one("sub_pos", 16'h0005, 16'h0002, 3'b001, 4'd2, 16'h0003, 1'b0, 1'b0);
    run_one("and",     16'h0F0F, 16'hF0F0, 3'b010, 4'd4, 16'h0000, 1'b0, 1'b0);
    run_one("or",      16'h0F0F, 16'hF0F0, 3'b011, 4'd5, 16'hFFFF, 1'b0, 1'b0);
    run_one("xor",     16'hAAAA, 16'h5555, 3'b100, 4'd6, 16'hFFFF, 1'b0, 1'b0);
    run_one("not",     16'h1234, 16'h9999, 3'b101, 4'd7, 16'hEDCB, 1'b0, 1'b0);
    run_one("shl",     16'h0001, 16'hFFFF, 3'b110, 4'd8, 16'h0002, 1'b0, 1'b0);
    run_one("shr",     16'h8000, 16'hFFFF, 3'b111, 4'd9, 16'h4000, 1'b0, 1'b0);
    run_one("shl_out", 16'h8000, 16'hFFFF, 3'b110, 4'd10, 16'h0000, 1'b0, 1'b0);
    @(negedge clk);
    chk("directed_done", 32'(done_count), 32'd10);

    // Backpressure: consumer stalled, producer always valid.
    rsp_ready = 1'b0;
    acc = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      cmd_valid = 1'b1;
      cmd_x = 16'($urandom); cmd_y = 16'($urandom);
      cmd_sel = 3'($urandom_range(0, 7)); cmd_tag = 4'(i);
      @(negedge clk);
      if (cmd_ready) acc++;
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    chk("bp_accepts", 32'(acc), 32'(DEPTH));
    @(negedge clk);
    chk("bp_full_ready", 32'(cmd_ready), 32'd0);
    rsp_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      chk("bp_pop_valid", 32'(rsp_valid), 32'd1);
      chk("bp_pop_tag", 32'(rsp_tag), 32'(i));
      @(negedge clk);
    end
    chk("bp_ready_back", 32'(cmd_ready), 32'd1);
    chk("bp_drained", 32'(rsp_valid), 32'd0);

    // Reset with three queued results and one in s1.
    rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      cmd_valid = 1'b1;
      cmd_x = 16'($urandom); cmd_y = 16'($urandom);
      cmd_sel = 3'($urandom_range(0, 7)); cmd_tag = 4'(8 + i);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    cmd_tag = 4'd15;
    @(negedge clk);
    chk("mid_rst_ready", 32'(cmd_ready), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("mid_rst_valid", 32'(rsp_valid), 32'd0);
    chk("mid_rst_done", 32'(done_count), 32'd0);
    rsp_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("no_stale", 32'(rsp_valid), 32'd0);
    end

    // Streaming: 20 back-to-back commands with consumer always ready.
    rsp_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      cmd_valid = 1'b1;
      cmd_x = 16'($urandom); cmd_y = 16'($urandom);
      cmd_sel = 3'($urandom_range(0, 7)); cmd_tag = 4'($urandom);
      @(negedge clk);
      chk("stream_ready", 32'(cmd_ready), 32'd1);
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("stream_done", 32'(done_count), 32'h0014);

    // Random traffic with random backpressure.
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      cmd_valid = ($urandom_range(0, 3) != 0);
      cmd_x = 16'($urandom); cmd_y = 16'($urandom);
      cmd_sel = 3'($urandom_range(0, 7)); cmd_tag = 4'($urandom);
      rsp_ready = ($urandom_range(0, 2) != 0);
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("final_drained", 32'(rsp_valid), 32'd0);
    chk("final_ready", 32'(cmd_ready), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alu_cmd_engine.md
ALU_CMD_ENGINE -- requirements
Module: alu_cmd_engine

Interface
REQ-001 Parameter: FIFO_DEPTH, 4, result FIFO entries; power of two, minimum 2.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  reset, synchronous, active-high.
REQ-004 Port: cmd_valid  input  1  command present.
REQ-005 Port: cmd_ready  output  1  engine accepts command this cycle.
REQ-006 Port: cmd_x  input  16  operand X.
REQ-007 Port: cmd_y  input  16  operand Y; ignored for sel 101/110/111.
REQ-008 Port: cmd_sel  input  3  opcode.
REQ-009 Port: cmd_tag  input  4  initiator tag, returned unchanged with result.
REQ-010 Port: rsp_valid  output  1  result present at FIFO head.
REQ-011 Port: rsp_ready  input  1  consumer takes result this cycle.
REQ-012 Port: rsp_data  output  16  result value.
REQ-013 Port: rsp_carry  output  1  carry flag.
REQ-014 Port: rsp_borrow  output  1  borrow flag.
REQ-015 Port: rsp_tag  output  4  tag of the command producing this result.
REQ-016 Port: done_count  output  16  number of results popped since reset.

Function
REQ-017 Opcodes SHALL be: 000 X+Y, 001 X-Y, 010 X&Y, 011 X|Y, 100 X^Y, 101 ~X, 110 X<<1 (zero fill), 111 X>>1 logical (zero fill).
REQ-018 ADD SHALL compute 17-bit sum; rsp_data = sum[15:0], rsp_carry = sum[16], rsp_borrow = 0.
REQ-019 SUB SHALL give rsp_data = (X-Y) mod 2^16, rsp_borrow = 1 iff X < Y unsigned, rsp_carry = 0.
REQ-020 All other opcodes SHALL drive rsp_carry = 0 and rsp_borrow = 0; bits shifted out are discarded.
REQ-021 Command accept SHALL occur on a rising edge where cmd_valid and cmd_ready are both 1.
REQ-022 Pipeline: accepted command captured into execute stage register (s1) at accept edge k; computed result written into result FIFO at edge k+1; result visible on rsp_* in cycle after edge k+1 when FIFO was empty.
REQ-023 Result pop SHALL occur on a rising edge where rsp_valid and rsp_ready are both 1; rsp_* SHALL show the oldest unpopped result and hold stable while rsp_valid=1 and rsp_ready=0.
REQ-024 cmd_ready SHALL be 1 iff (fifo_count + s1_valid) < FIFO_DEPTH, derived from registers only, no combinational path from rsp_ready or cmd_valid.
REQ-025 rsp_valid SHALL equal (fifo_count != 0).
REQ-026 Simultaneous FIFO write and pop in one edge SHALL leave fifo_count unchanged and lose no entry, including at count 0 (write only effective) and count FIFO_DEPTH (pop frees slot, write takes it).
REQ-027 Results SHALL leave in strict acceptance order; no drop, no duplication.
REQ-028 FIFO pointers SHALL wrap modulo FIFO_DEPTH; fifo_count range 0..FIFO_DEPTH.
REQ-029 done_count SHALL increment by 1 on each pop and wrap FFFF -> 0000.
REQ-030 Sustained throughput SHALL be one command per cycle when rsp_ready held 1.
REQ-031 s1 states: EMPTY (s1_valid=0) and LOADED (s1_valid=1); EMPTY->LOADED on accept; LOADED->LOADED on accept; LOADED->EMPTY when no accept.

Reset
REQ-032 While rst=1 at a rising edge: s1_valid=0, fifo_count=0, pointers=0, done_count=0; cmd_ready SHALL read 0 during rst=1 cycles.
REQ-033 After reset: rsp_valid=0, cmd_ready=1, done_count=0000; rsp_data/carry/borrow/tag=0.
REQ-034 Reset mid-operation SHALL discard s1 and all FIFO contents; no result from pre-reset commands SHALL appear afterwards; cmd handshakes during rst=1 SHALL be ignored.

Verification
REQ-035 ADD: X=FFFF, Y=0001, sel=000, tag=3 -> rsp_data=0000, carry=1, borrow=0, tag=3, rsp_valid 2 edges after accept.
REQ-036 SUB: X=0001, Y=0002, sel=001 -> rsp_data=FFFF, borrow=1; X=0005, Y=0002 -> 0003, borrow=0.
REQ-037 Logic/shift: 0F0F&F0F0=0000, 0F0F|F0F0=FFFF, AAAA^5555=FFFF, ~1234=EDCB, 0001<<1=0002, 8000>>1=4000, 8000<<1=0000 carry=0.
REQ-038 Backpressure: rsp_ready=0, cmd_valid=1 continuously -> exactly FIFO_DEPTH accepts then cmd_ready=0; raise rsp_ready -> results pop in tag order, one per cycle, cmd_ready returns 1.
REQ-039 Streaming: 20 random commands, rsp_ready=1 -> one accept per cycle, all results match golden model in order, done_count=0014.
REQ-040 Reset with 3 results queued and 1 in s1 -> next cycle rsp_valid=0, done_count=0000, no stale result ever emitted.
